// File: rtl/keypad_event_decoder_pkg.sv
// Shared constants and helpers for the keypad event decoder: key count, event
// entry layout and the counter-width function.
package keypad_event_decoder_pkg;

  localparam int NUM_KEYS      = 20;
  localparam int KEY_IDX_W     = 5;
  localparam int EVT_W         = KEY_IDX_W + 1;
  localparam int EVT_PRESS_BIT = 0;
  localparam int EVT_KEY_LSB   = 1;

  // Bits needed to hold the values 0..n-1; never narrower than one bit.
  function automatic int get_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/keypad_event_decoder_evt_fifo.sv
// Generic synchronous FIFO with a combinational head output; pushes into a
// full FIFO and pops from an empty one are ignored.
module keypad_event_decoder_evt_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && (count_q != CNT_W'(DEPTH));
    do_pop   = pop && (count_q != '0);
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/keypad_event_decoder.sv
// Debounces the scanned key levels on a periodic sample tick and queues
// accepted press/release changes as events behind a valid/ready handshake.
module keypad_event_decoder
  import keypad_event_decoder_pkg::*;
#(
  parameter int SAMPLE_CYCLES  = 1000000,
  parameter int STABLE_SAMPLES = 3,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_KEYS-1:0]  keys_raw,
  output logic [NUM_KEYS-1:0]  keys_stable,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [KEY_IDX_W-1:0] evt_key,
  output logic                 evt_press,
  output logic                 overflow
);

  localparam int TICK_W = get_width(SAMPLE_CYCLES);
  localparam int CNT_W  = get_width(STABLE_SAMPLES);
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [CNT_W-1:0]     cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]     cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0]  stable_q, stable_d;
  logic [NUM_KEYS-1:0]  pending_q, pending_d;
  logic                 overflow_q, overflow_d;
  logic [NUM_KEYS-1:0]  flip;
  logic                 tick, emit;
  logic [KEY_IDX_W-1:0] emit_key;
  logic [EVT_W-1:0]     evt_wdata, evt_rdata;
  logic [FCNT_W-1:0]    fifo_count;

  always_comb begin
    tick   = (tick_q == TICK_W'(SAMPLE_CYCLES - 1));
    tick_d = tick ? '0 : tick_q + 1'b1;

    cnt_d    = cnt_q;
    stable_d = stable_q;
    flip     = '0;
    if (tick) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (keys_raw[i] == stable_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_W'(STABLE_SAMPLES - 1)) begin
          stable_d[i] = ~stable_q[i];
          cnt_d[i]    = '0;
          flip[i]     = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    // Descending scan so the lowest pending index wins.
    emit_key = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        emit_key = KEY_IDX_W'(i);
      end
    end
    emit = (pending_q != '0) && (fifo_count < FCNT_W'(FIFO_DEPTH));

    evt_wdata                               = '0;
    evt_wdata[EVT_PRESS_BIT]                = stable_q[emit_key];
    evt_wdata[EVT_KEY_LSB +: KEY_IDX_W]     = emit_key;

    pending_d  = pending_q;
    overflow_d = 1'b0;
    if (emit) begin
      pending_d[emit_key] = 1'b0;
    end
    // A second flip while still pending cancels out, unless the first one is
    // leaving for the FIFO right now, in which case the new level is queued.
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (flip[i]) begin
        if (!pending_q[i] || (emit && emit_key == KEY_IDX_W'(i))) begin
          pending_d[i] = 1'b1;
        end else begin
          pending_d[i] = 1'b0;
          overflow_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt_q[i] <= '0;
      end
      stable_q   <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      cnt_q      <= cnt_d;
      stable_q   <= stable_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  keypad_event_decoder_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (emit),
    .wdata (evt_wdata),
    .pop   (evt_ready),
    .rdata (evt_rdata),
    .count (fifo_count)
  );

  assign keys_stable = stable_q;
  assign evt_valid   = (fifo_count != '0);
  assign evt_key     = evt_rdata[EVT_KEY_LSB +: KEY_IDX_W];
  assign evt_press   = evt_rdata[EVT_PRESS_BIT];
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_keypad_event_decoder.sv
// Directed bench for keypad_event_decoder with a 4-cycle sample period:
// table-driven debounce rows plus hand-written backpressure/overflow/reset cases.
module tb_keypad_event_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] keys_raw;
  logic [19:0] keys_stable;
  logic        evt_valid;
  logic        evt_ready;
  logic [4:0]  evt_key;
  logic        evt_press;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  logic [5:0] evq [$];
  int         ovf_cnt = 0;

  keypad_event_decoder #(
    .SAMPLE_CYCLES  (4),
    .STABLE_SAMPLES (3),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .keys_raw    (keys_raw),
    .keys_stable (keys_stable),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_key     (evt_key),
    .evt_press   (evt_press),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && evt_valid && evt_ready) evq.push_back({evt_key, evt_press});
    if (!rst && overflow) ovf_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [19:0] raw;
    int          ncyc;
    logic [19:0] exp_stable;
    int          exp_n;
    int          first_key;
    logic        first_p;
    int          last_key;
    logic        last_p;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] ev(input int key, input logic press);
    return 32'((key << 1) | int'(press));
  endfunction

  initial begin
    int base, n, ob;
    vec_t v;

    rst = 1'b1; keys_raw = '0; evt_ready = 1'b1;
    wait_n(3);
    check("reset keys_stable", 32'(keys_stable), 0);
    check("reset evt_valid", 32'(evt_valid), 0);
    check("reset evt_key", 32'(evt_key), 0);
    check("reset evt_press", 32'(evt_press), 0);
    check("reset overflow", 32'(overflow), 0);
    rst = 1'b0;   // negedge: next tick edge is 4 posedges later

    // Test 1: press key 2, exact latency
    base = evq.size();
    keys_raw = 20'h00004;
    wait_n(12);
    check("t1 stable after 3rd tick", 32'(keys_stable), 32'h4);
    check("t1 valid at T+1", 32'(evt_valid), 0);
    wait_n(1);
    check("t1 valid at T+2", 32'(evt_valid), 1);
    check("t1 key", 32'(evt_key), 2);
    check("t1 press", 32'(evt_press), 1);
    wait_n(1);
    check("t1 valid after pop", 32'(evt_valid), 0);
    wait_n(2);
    check("t1 event count", 32'(evq.size() - base), 1);

    // Table: release key 2, bounce on key 5, simultaneous keys 0 and 19
    ob = ovf_cnt;
    vecs.push_back(vec_t'{20'h00000, 16, 20'h00000, 1,  2, 1'b0,  2, 1'b0});
    vecs.push_back(vec_t'{20'h00020,  4, 20'h00000, 0,  0, 1'b0,  0, 1'b0});
    vecs.push_back(vec_t'{20'h00020,  4, 20'h00000, 0,  0, 1'b0,  0, 1'b0});
    vecs.push_back(vec_t'{20'h00000,  4, 20'h00000, 0,  0, 1'b0,  0, 1'b0});
    vecs.push_back(vec_t'{20'h00020,  4, 20'h00000, 0,  0, 1'b0,  0, 1'b0});
    vecs.push_back(vec_t'{20'h00020,  4, 20'h00000, 0,  0, 1'b0,  0, 1'b0});
    vecs.push_back(vec_t'{20'h00020,  4, 20'h00020, 0,  0, 1'b0,  0, 1'b0});
    vecs.push_back(vec_t'{20'h00020,  4, 20'h00020, 1,  5, 1'b1,  5, 1'b1});
    vecs.push_back(vec_t'{20'h00000, 16, 20'h00000, 1,  5, 1'b0,  5, 1'b0});
    vecs.push_back(vec_t'{20'h80001, 16, 20'h80001, 2,  0, 1'b1, 19, 1'b1});
    vecs.push_back(vec_t'{20'h00000, 16, 20'h00000, 2,  0, 1'b0, 19, 1'b0});
    for (int r = 0; r < vecs.size(); r++) begin
      v = vecs[r];
      base = evq.size();
      keys_raw = v.raw;
      wait_n(v.ncyc);
      n = evq.size() - base;
      check($sformatf("row%0d stable", r), 32'(keys_stable), 32'(v.exp_stable));
      check($sformatf("row%0d events", r), 32'(n), 32'(v.exp_n));
      if (v.exp_n > 0 && n > 0) begin
        check($sformatf("row%0d first", r), 32'(evq[base]), ev(v.first_key, v.first_p));
        check($sformatf("row%0d last", r), 32'(evq[evq.size()-1]), ev(v.last_key, v.last_p));
      end
    end
    check("table overflow pulses", 32'(ovf_cnt - ob), 0);

    // Test 4: backpressure, six presses into a four-entry queue
    ob = ovf_cnt;
    evt_ready = 1'b0;
    base = evq.size();
    keys_raw = 20'h0003F;
    wait_n(16);
    check("t4 valid while held", 32'(evt_valid), 1);
    check("t4 head key", 32'(evt_key), 0);
    wait_n(4);
    check("t4 head key stable", 32'(evt_key), 0);
    check("t4 head press stable", 32'(evt_press), 1);
    check("t4 nothing popped", 32'(evq.size() - base), 0);
    evt_ready = 1'b1;
    wait_n(8);
    check("t4 drained count", 32'(evq.size() - base), 6);
    if (evq.size() - base == 6)
      for (int i = 0; i < 6; i++)
        check($sformatf("t4 order %0d", i), 32'(evq[base+i]), ev(i, 1'b1));
    base = evq.size();
    keys_raw = 20'h0;
    wait_n(20);
    check("t4 release count", 32'(evq.size() - base), 6);
    if (evq.size() - base == 6)
      check("t4 release last", 32'(evq[evq.size()-1]), ev(5, 1'b0));
    check("t4 overflow pulses", 32'(ovf_cnt - ob), 0);

    // Test 5: key 7 press then release lost while the queue is full
    ob = ovf_cnt;
    evt_ready = 1'b0;
    base = evq.size();
    keys_raw = 20'h0000F;
    wait_n(16);
    keys_raw = 20'h0008F;
    wait_n(12);
    check("t5 key7 stable pressed", 32'(keys_stable), 32'h8F);
    check("t5 no overflow yet", 32'(ovf_cnt - ob), 0);
    keys_raw = 20'h0000F;
    wait_n(16);
    check("t5 overflow one pulse", 32'(ovf_cnt - ob), 1);
    check("t5 stable", 32'(keys_stable), 32'hF);
    evt_ready = 1'b1;
    wait_n(8);
    check("t5 drained count", 32'(evq.size() - base), 4);
    if (evq.size() - base == 4)
      for (int i = 0; i < 4; i++)
        check($sformatf("t5 order %0d", i), 32'(evq[base+i]), ev(i, 1'b1));
    base = evq.size();
    keys_raw = 20'h0;
    wait_n(20);
    check("t5 release count", 32'(evq.size() - base), 4);

    // Test 6: async reset with events queued and key 1 held
    evt_ready = 1'b0;
    keys_raw = 20'h00003;
    wait_n(16);
    check("t6 valid before reset", 32'(evt_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("t6 valid in reset", 32'(evt_valid), 0);
    check("t6 stable in reset", 32'(keys_stable), 0);
    @(negedge clk);
    keys_raw = 20'h00002;
    evt_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    base = evq.size();
    wait_n(12);
    check("t6 stable after 3 ticks", 32'(keys_stable), 32'h2);
    check("t6 no early event", 32'(evq.size() - base), 0);
    wait_n(4);
    check("t6 event count", 32'(evq.size() - base), 1);
    if (evq.size() - base == 1)
      check("t6 press key1", 32'(evq[base]), ev(1, 1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
